// File: rtl/mips_processor_pkg.sv
// rtl/mips_processor_pkg.sv - opcode/funct constants, ALU and write-back enums, register indices
package mips_processor_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0a;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_SLT  = 6'h2a;

   // rt field selects the condition under the REGIMM opcode
   localparam logic [4:0] RT_BLTZ = 5'd0;
   localparam logic [4:0] RT_BGEZ = 5'd1;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_A0   = 5'd4;
   localparam logic [4:0] REG_A1   = 5'd5;
   localparam logic [4:0] REG_T0   = 5'd8;
   localparam logic [4:0] REG_S0   = 5'd16;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
   } alu_op_t;

   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_t;

endpackage

// File: rtl/mips_processor_alu.sv
// rtl/mips_processor_alu.sv - 32-bit wrap-around ALU; shifts take their operand from b
module mips_processor_alu
   import mips_processor_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLL: y = b << shamt;
         ALU_SRL: y = b >> shamt;
         ALU_LUI: y = {b[15:0], 16'h0000};
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/mips_processor_bytemem.sv
// rtl/mips_processor_bytemem.sv - big-endian byte array, combinational word read, word write
module mips_processor_bytemem #(
   parameter int BYTES = 1024
) (
   input  logic        clk,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int AW = $clog2(BYTES);

   logic [7:0]    bytes [0:BYTES-1];
   logic [AW-1:0] base;
   logic          unused_addr;

   // Upper bits wrap and the low two are ignored: accesses are word aligned
   assign base        = {addr[AW-1:2], 2'b00};
   assign unused_addr = ^{addr[31:AW], addr[1:0]};

   assign rdata = {bytes[base], bytes[base + AW'(1)], bytes[base + AW'(2)], bytes[base + AW'(3)]};

   always_ff @(posedge clk) begin
      if (we) begin
         bytes[base]          <= wdata[31:24];
         bytes[base + AW'(1)] <= wdata[23:16];
         bytes[base + AW'(2)] <= wdata[15:8];
         bytes[base + AW'(3)] <= wdata[7:0];
      end
   end

endmodule

// File: rtl/mips_processor_ifu.sv
// rtl/mips_processor_ifu.sv - fetch unit: program counter register and instruction memory
module mips_processor_ifu #(
   parameter int IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_next,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   always_ff @(posedge clk) begin
      if (reset)
         pc <= '0;
      else
         pc <= pc_next;
   end

   mips_processor_imem #(.BYTES(IMEM_BYTES)) imemory (
      .clk   (clk),
      .addr  (pc),
      .instr (instr)
   );

endmodule

// File: rtl/mips_processor_imem.sv
// rtl/mips_processor_imem.sv - read-only instruction memory; contents are preloaded into storage.bytes
module mips_processor_imem #(
   parameter int BYTES = 1024
) (
   input  logic        clk,
   input  logic [31:0] addr,
   output logic [31:0] instr
);

   mips_processor_bytemem #(.BYTES(BYTES)) storage (
      .clk   (clk),
      .we    (1'b0),
      .addr  (addr),
      .wdata (32'h0),
      .rdata (instr)
   );

endmodule

// File: rtl/mips_processor_regfile.sv
// rtl/mips_processor_regfile.sv - 32x32 register file, two combinational reads, $0 hardwired to zero
module mips_processor_regfile
   import mips_processor_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] registers [0:31];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            registers[i] <= '0;
      end else if (we && wa != REG_ZERO) begin
         registers[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == REG_ZERO) ? '0 : registers[ra1];
   assign rd2 = (ra2 == REG_ZERO) ? '0 : registers[ra2];

endmodule

// File: rtl/mips_processor.sv
// rtl/mips_processor.sv - single-cycle MIPS-subset CPU; PROCESSOR_ZERO_BRANCH_EN adds blez/bgtz/bltz/bgez
module mips_processor
   import mips_processor_pkg::*;
#(
   parameter int IMEM_BYTES = 1024,
   parameter int DMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc
);

   logic [31:0] instr, pc_next, pc4, rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data;
   logic [31:0] imm_sext, imm_zext, br_target, j_target;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, wr_reg;
   logic        reg_we, mem_we;
   alu_op_t     alu_op;
   wb_sel_t     wb_sel;

   assign op       = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign shamt    = instr[10:6];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext = {16'h0000, instr[15:0]};
   assign pc4      = pc + 32'd4;
   assign br_target = pc4 + {imm_sext[29:0], 2'b00};
   assign j_target  = {pc4[31:28], instr[25:0], 2'b00};

   mips_processor_ifu #(.IMEM_BYTES(IMEM_BYTES)) IFU (
      .clk     (clk),
      .reset   (reset),
      .pc_next (pc_next),
      .pc      (pc),
      .instr   (instr)
   );

   mips_processor_regfile registers (
      .clk   (clk),
      .reset (reset),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rs_val),
      .rd2   (rt_val),
      .we    (reg_we),
      .wa    (wr_reg),
      .wd    (wb_data)
   );

   mips_processor_alu alu (
      .op    (alu_op),
      .a     (rs_val),
      .b     (alu_b),
      .shamt (shamt),
      .y     (alu_y)
   );

   // A store in flight when reset hits must not commit
   mips_processor_bytemem #(.BYTES(DMEM_BYTES)) dmemory (
      .clk   (clk),
      .we    (mem_we & ~reset),
      .addr  (alu_y),
      .wdata (rt_val),
      .rdata (mem_rdata)
   );

   always_comb begin
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      wr_reg  = rt;
      wb_sel  = WB_ALU;
      alu_op  = ALU_ADD;
      alu_b   = rt_val;
      pc_next = pc4;
      case (op)
         OP_RTYPE: begin
            wr_reg = rd;
            case (funct)
               F_ADD, F_ADDU: begin reg_we = 1'b1; alu_op = ALU_ADD; end
               F_SUB, F_SUBU: begin reg_we = 1'b1; alu_op = ALU_SUB; end
               F_AND:         begin reg_we = 1'b1; alu_op = ALU_AND; end
               F_OR:          begin reg_we = 1'b1; alu_op = ALU_OR;  end
               F_SLT:         begin reg_we = 1'b1; alu_op = ALU_SLT; end
               F_SLL:         begin reg_we = 1'b1; alu_op = ALU_SLL; end
               F_SRL:         begin reg_we = 1'b1; alu_op = ALU_SRL; end
               F_JR:          pc_next = rs_val;
               default: ;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; alu_b = imm_sext; end
         OP_SLTI: begin reg_we = 1'b1; alu_b = imm_sext; alu_op = ALU_SLT; end
         OP_ANDI: begin reg_we = 1'b1; alu_b = imm_zext; alu_op = ALU_AND; end
         OP_ORI:  begin reg_we = 1'b1; alu_b = imm_zext; alu_op = ALU_OR;  end
         OP_LUI:  begin reg_we = 1'b1; alu_b = imm_zext; alu_op = ALU_LUI; end
         OP_LW:   begin reg_we = 1'b1; alu_b = imm_sext; wb_sel = WB_MEM; end
         OP_SW:   begin mem_we = 1'b1; alu_b = imm_sext; end
         OP_BEQ:  if (rs_val == rt_val) pc_next = br_target;
         OP_BNE:  if (rs_val != rt_val) pc_next = br_target;
         OP_J:    pc_next = j_target;
         OP_JAL: begin
            reg_we  = 1'b1;
            wr_reg  = REG_RA;
            wb_sel  = WB_LINK;
            pc_next = j_target;
         end
`ifdef PROCESSOR_ZERO_BRANCH_EN
         OP_BLEZ: if ($signed(rs_val) <= 0) pc_next = br_target;
         OP_BGTZ: if ($signed(rs_val) > 0)  pc_next = br_target;
         OP_REGIMM: begin
            if (rt == RT_BLTZ && $signed(rs_val) < 0)
               pc_next = br_target;
            else if (rt == RT_BGEZ && $signed(rs_val) >= 0)
               pc_next = br_target;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      case (wb_sel)
         WB_MEM:  wb_data = mem_rdata;
         WB_LINK: wb_data = pc4;
         default: wb_data = alu_y;
      endcase
   end

endmodule

// File: tb/tb_mips_processor.sv
// tb/tb_mips_processor.sv - ISA-level reference model with per-cycle compare plus hand-computed checks
module tb_mips_processor;
   import mips_processor_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc;

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   logic [31:0] prog [0:255];
   logic [31:0] mreg [0:31];
   logic [31:0] mdm  [0:255];
   logic [31:0] mpc;

   always #5 clk = ~clk;

   mips_processor #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) CPU (
      .clk   (clk),
      .reset (reset),
      .pc    (pc)
   );

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] target);
      return {op, target[27:2]};
   endfunction

   task automatic put(input logic [31:0] addr, input logic [31:0] w);
      prog[addr[9:2]] = w;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      mpc = 32'h0;
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
   endtask

   // Architectural interpreter: executes one instruction from the bench's own program copy
   task automatic model_step();
      logic [31:0] w, a, b, pc4, sx, zx, res, npc;
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, sh, dst;
      logic        wr;
      w  = prog[mpc[9:2]];
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
      a  = mreg[rs]; b = mreg[rt];
      pc4 = mpc + 4;
      sx  = {{16{w[15]}}, w[15:0]};
      zx  = {16'h0, w[15:0]};
      npc = pc4; wr = 1'b0; dst = rt; res = 32'h0;
      case (op)
         6'd0: begin
            dst = rd;
            case (fn)
               6'd0:  begin wr = 1; res = b << sh; end
               6'd2:  begin wr = 1; res = b >> sh; end
               6'd8:  npc = a;
               6'd32, 6'd33: begin wr = 1; res = a + b; end
               6'd34, 6'd35: begin wr = 1; res = a - b; end
               6'd36: begin wr = 1; res = a & b; end
               6'd37: begin wr = 1; res = a | b; end
               6'd42: begin wr = 1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
               default: ;
            endcase
         end
         6'd8, 6'd9: begin wr = 1; res = a + sx; end
         6'd10: begin wr = 1; res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
         6'd12: begin wr = 1; res = a & zx; end
         6'd13: begin wr = 1; res = a | zx; end
         6'd15: begin wr = 1; res = w[15:0] * 32'h10000; end
         6'd35: begin wr = 1; res = mdm[(a + sx) / 4 % 256]; end
         6'd43: mdm[(a + sx) / 4 % 256] = b;
         6'd4:  if (a == b) npc = pc4 + sx * 4;
         6'd5:  if (a != b) npc = pc4 + sx * 4;
         6'd2:  npc = {pc4[31:28], w[25:0], 2'b00};
         6'd3:  begin npc = {pc4[31:28], w[25:0], 2'b00}; wr = 1; dst = 5'd31; res = pc4; end
`ifdef PROCESSOR_ZERO_BRANCH_EN
         6'd6:  if ($signed(a) <= 0) npc = pc4 + sx * 4;
         6'd7:  if ($signed(a) > 0)  npc = pc4 + sx * 4;
         6'd1: begin
            if (rt == 5'd0 && $signed(a) < 0)  npc = pc4 + sx * 4;
            if (rt == 5'd1 && $signed(a) >= 0) npc = pc4 + sx * 4;
         end
`endif
         default: ;
      endcase
      if (wr && dst != 5'd0) mreg[dst] = res;
      mpc = npc;
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else       model_step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pc", pc, mpc);
         for (int i = 0; i < 32; i++)
            check($sformatf("reg%0d", i), CPU.registers.registers[i], mreg[i]);
      end
   end

   function automatic logic [31:0] dmem_word8();
      return {CPU.dmemory.bytes[8], CPU.dmemory.bytes[9], CPU.dmemory.bytes[10], CPU.dmemory.bytes[11]};
   endfunction

   initial begin
      logic [31:0] orall;
      logic [31:0] exp_t8;
      for (int i = 0; i < 256; i++) begin prog[i] = 32'h0; mdm[i] = 32'h0; end
      put(32'h00, i_ins(6'd8, 5'd0, REG_S0, 16'd4));
      put(32'h04, i_ins(6'd8, 5'd0, REG_A1, 16'd2));
      put(32'h08, r_ins(REG_S0, REG_A1, REG_T0, 5'd0, 6'd32));
      put(32'h0C, r_ins(REG_A1, REG_A1, REG_A0, 5'd0, 6'd34));
      put(32'h10, j_ins(6'd2, 32'h40));
      put(32'h20, r_ins(REG_RA, 5'd0, 5'd0, 5'd0, 6'd8));
      put(32'h24, i_ins(6'd8, 5'd0, REG_T0, 16'd111));
      put(32'h40, i_ins(6'd4, REG_A0, 5'd0, 16'd2));
      put(32'h44, i_ins(6'd8, 5'd0, REG_T0, 16'd99));
      put(32'h48, i_ins(6'd8, 5'd0, REG_A1, 16'd77));
      put(32'h4C, i_ins(6'd8, 5'd0, 5'd9, 16'd1));
      put(32'h50, i_ins(6'd5, REG_A0, 5'd0, 16'd3));
      put(32'h54, i_ins(6'd8, REG_S0, REG_S0, 16'd20));
      put(32'h58, i_ins(6'd43, 5'd0, REG_S0, 16'd8));
      put(32'h5C, i_ins(6'd35, 5'd0, REG_T0, 16'd8));
      put(32'h60, j_ins(6'd3, 32'h20));
      put(32'h64, i_ins(6'd8, 5'd0, 5'd0, 16'd5));
      put(32'h68, i_ins(6'd8, REG_T0, 5'd10, 16'd1));
      put(32'h6C, i_ins(6'd13, 5'd0, 5'd11, 16'hF0F0));
      put(32'h70, i_ins(6'd12, 5'd11, 5'd12, 16'h00FF));
      put(32'h74, i_ins(6'd15, 5'd0, 5'd13, 16'h8000));
      put(32'h78, r_ins(5'd13, REG_S0, 5'd14, 5'd0, 6'd42));
      put(32'h7C, i_ins(6'd10, REG_S0, 5'd15, 16'hFFFF));
      put(32'h80, r_ins(5'd0, REG_S0, 5'd17, 5'd2, 6'd0));
      put(32'h84, r_ins(5'd0, 5'd13, 5'd18, 5'd4, 6'd2));
      put(32'h88, r_ins(5'd0, REG_S0, 5'd19, 5'd0, 6'd35));
      put(32'h8C, i_ins(6'd9, 5'd0, 5'd20, 16'hFFFF));
      put(32'h90, r_ins(5'd20, 5'd20, 5'd21, 5'd0, 6'd33));
      put(32'h94, r_ins(5'd11, 5'd12, 5'd22, 5'd0, 6'd36));
      put(32'h98, r_ins(5'd11, 5'd13, 5'd23, 5'd0, 6'd37));
      put(32'h9C, 32'hFC00_0000);
      put(32'hA0, r_ins(REG_S0, REG_S0, REG_T0, 5'd0, 6'h3F));
      put(32'hA4, i_ins(6'd6, REG_S0, 5'd0, 16'd1));
      put(32'hA8, i_ins(6'd7, REG_S0, 5'd0, 16'd1));
      put(32'hAC, i_ins(6'd8, 5'd0, 5'd24, 16'd5));
      put(32'hB0, i_ins(6'd1, REG_S0, 5'd1, 16'd1));
      put(32'hB4, i_ins(6'd8, 5'd0, 5'd25, 16'd6));
      put(32'hB8, i_ins(6'd1, REG_S0, 5'd0, 16'd1));
      put(32'hBC, i_ins(6'd8, 5'd0, 5'd2, 16'd7));
      put(32'hC0, j_ins(6'd2, 32'hC0));
      for (int i = 0; i < 256; i++) begin
         CPU.IFU.imemory.storage.bytes[10'(4*i)]     = prog[i][31:24];
         CPU.IFU.imemory.storage.bytes[10'(4*i + 1)] = prog[i][23:16];
         CPU.IFU.imemory.storage.bytes[10'(4*i + 2)] = prog[i][15:8];
         CPU.IFU.imemory.storage.bytes[10'(4*i + 3)] = prog[i][7:0];
      end
`ifdef PROCESSOR_ZERO_BRANCH_EN
      exp_t8 = 32'd0;
`else
      exp_t8 = 32'd5;
`endif

      @(negedge clk);
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("reset_pc", pc, 32'h0);
      reset = 1'b0;

      run(4);
      check("alu_s0", CPU.registers.registers[REG_S0], 32'd4);
      check("alu_a1", CPU.registers.registers[REG_A1], 32'd2);
      check("alu_t0", CPU.registers.registers[REG_T0], 32'd6);
      check("alu_a0", CPU.registers.registers[REG_A0], 32'd0);
      run(2);
      check("beq_pc", pc, 32'h4C);
      run(1);
      check("beq_land_t1", CPU.registers.registers[9], 32'd1);
      check("beq_skip_t0", CPU.registers.registers[REG_T0], 32'd6);
      check("beq_skip_a1", CPU.registers.registers[REG_A1], 32'd2);
      run(2);
      check("bne_s0", CPU.registers.registers[REG_S0], 32'd24);
      check("bne_a0", CPU.registers.registers[REG_A0], 32'd0);
      check("bne_a1", CPU.registers.registers[REG_A1], 32'd2);
      run(2);
      check("lw_t0", CPU.registers.registers[REG_T0], 32'd24);
      check("sw_bytes", dmem_word8(), 32'h0000_0018);
      run(1);
      check("jal_ra", CPU.registers.registers[REG_RA], 32'h64);
      check("jal_pc", pc, 32'h20);
      run(1);
      check("jr_pc", pc, 32'h64);
      run(1);
      check("zero_reg", CPU.registers.registers[REG_ZERO], 32'h0);
      run(60);
      check("final_pc", pc, 32'hC0);
      check("lui_t5", CPU.registers.registers[13], 32'h8000_0000);
      check("slt_t6", CPU.registers.registers[14], 32'd1);
      check("subu_s3", CPU.registers.registers[19], 32'hFFFF_FFE8);
      check("addu_s5", CPU.registers.registers[21], 32'hFFFF_FFFE);
      check("or_s7", CPU.registers.registers[23], 32'h8000_F0F0);
      check("badfn_t0", CPU.registers.registers[REG_T0], 32'd24);
      check("v0", CPU.registers.registers[2], 32'd7);
      check("zbr_t8", CPU.registers.registers[24], exp_t8);

      // Restart, then hit reset while the store at 0x58 is in flight
      reset = 1'b1;
      tick();
      reset = 1'b0;
      run(9);
      reset = 1'b1;
      tick();
      orall = 32'h0;
      for (int i = 0; i < 32; i++) orall = orall | CPU.registers.registers[i];
      check("midreset_pc", pc, 32'h0);
      check("midreset_regs", orall, 32'h0);
      check("midreset_dmem", dmem_word8(), 32'h0000_0018);
      reset = 1'b0;
      run(4);
      check("rerun_s0", CPU.registers.registers[REG_S0], 32'd4);
      check("rerun_t0", CPU.registers.registers[REG_T0], 32'd6);
      run(70);
      check("rerun_pc", pc, 32'hC0);
      check("rerun_t8", CPU.registers.registers[24], exp_t8);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
